ramp_sweep_gen: RTL and testbench
=================================

RAMP_SWEEP_GEN -- requirements
Module: ramp_sweep_gen

Interface
REQ-001 The block SHALL have parameter NCH, default 2, meaning number of output channels.
REQ-002 The block SHALL have parameter W, default 8, meaning level code width.
REQ-003 The block SHALL have parameter TW, default 8, meaning tick-divider width.
REQ-004 The block SHALL have parameter CW, default 8, meaning cycle-count width.
REQ-005 The block SHALL have parameter VFS, default 1.5 (real), meaning the voltage of the full-scale code 2^W-1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock (rising edge).
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, which begins a sweep.
REQ-009 The block SHALL have port abort, input, 1 bit, which terminates a sweep.
REQ-010 The block SHALL have port mode, input, 2 bits: 0 triangle, 1 saw-up, 2 saw-down, 3 ramp-hold.
REQ-011 The block SHALL have ports lo and hi, input, W bits each, the sweep bounds.
REQ-012 The block SHALL have port step, input, W bits, the increment per step.
REQ-013 The block SHALL have port tick_div, input, TW bits, giving clocks per step = tick_div+1.
REQ-014 The block SHALL have port n_cycles, input, CW bits, the sweep cycles to run (0 = run until abort).
REQ-015 The block SHALL have port ch_inv, input, NCH bits; a set bit gives a complementary channel.
REQ-016 The block SHALL have port code_o, output, NCH x W, the per-channel level code.
REQ-017 The block SHALL have port v_o, output, NCH x real, the per-channel voltage = code_o*VFS/(2^W-1).
REQ-018 The block SHALL have ports busy, done, err and rising, output, 1 bit each.

Function
REQ-019 In IDLE with start=1 and lo<hi, the block SHALL latch mode/lo/hi/step/tick_div/n_cycles/ch_inv, set busy next cycle, and start at lo (saw-down: hi).
REQ-020 start while busy SHALL be ignored; the latched config SHALL not change mid-sweep.
REQ-021 start with lo>=hi SHALL stay IDLE and pulse err for 1 cycle; busy SHALL stay 0.
REQ-022 step=0 SHALL be treated as step=1.
REQ-023 The level SHALL change once per tick_div+1 clocks, with the first change tick_div+1 clocks after busy rises.
REQ-024 States SHALL be IDLE, UP, DOWN, HOLD.
REQ-025 UP SHALL compute next=min(cur+step,hi) in W+1 bits, with no wrap past hi.
REQ-026 DOWN SHALL compute next=max(cur-step,lo), with no underflow below lo.
REQ-027 Triangle: UP at hi SHALL go to DOWN; DOWN at lo SHALL complete one cycle and then go to UP.
REQ-028 Saw-up: UP at hi SHALL complete a cycle and restart at lo on the next step.
REQ-029 Saw-down: DOWN at lo SHALL complete a cycle and restart at hi on the next step.
REQ-030 Ramp-hold: UP at hi SHALL complete a cycle and go to HOLD; HOLD SHALL keep hi until abort, ignoring n_cycles, with busy=1 and done never pulsed.
REQ-031 When the completed-cycle count equals n_cycles (nonzero), the block SHALL go to IDLE, pulse done 1 cycle, and drop busy in that same cycle.
REQ-032 abort SHALL force IDLE next cycle with code returning to lo and no done pulse; abort outranks a simultaneous step, cycle completion or start.
REQ-033 rising SHALL be 1 in UP and 0 otherwise.
REQ-034 code_o[i] SHALL be cur when ch_inv[i]=0, else lo+hi-cur, computed in W+1 bits; channels SHALL update in the same cycle.
REQ-035 v_o SHALL track code_o in the same cycle as code_o.
REQ-036 In IDLE, code_o SHALL hold its last value, except after abort or reset.

Reset
REQ-037 While rst=1 at clk: state IDLE; code_o all 0; v_o all 0.0; busy, done, err and rising 0; cycle and tick counters 0.
REQ-038 Reset asserted mid-sweep SHALL take priority over every other input.

Structure
REQ-039 Shared package sweep_pkg SHALL hold the mode enum, the state enum and a code-to-volt conversion function.
REQ-040 One sub-module, sweep_tick (TW-bit divider emitting a 1-cycle step strobe, cleared on start/abort), SHALL be instantiated once.
REQ-041 The per-channel output stage SHALL be a generate loop over NCH.

Verification
REQ-042 Triangle test: lo=0, hi=10, step=3, tick_div=0, n=1 -> codes 0,3,6,9,10,7,4,1,0; done 1 cycle after the return to 0.
REQ-043 Saw-up test: lo=2, hi=8, step=2, tick_div=3, n=2 -> 2,4,6,8,2,4,6,8, each held 4 clocks; done then busy=0.
REQ-044 ch_inv test: ch_inv=2'b10, lo=0, hi=15, triangle -> ch1 = 15-ch0 every cycle; v_o[1]=VFS*ch1/255.
REQ-045 Error test: lo=9, hi=9, start -> err pulse, busy=0.
REQ-046 Abort and start-while-busy test: abort at code 6 coincident with a step strobe -> IDLE, code=lo next cycle, no done; start while busy with a new hi -> old hi still used.
REQ-047 Ramp-hold and reset test: ramp-hold hi=200, step=50, n=1 -> 0,50,100,150,200 then hold, busy=1, no done; rst mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the ramp/sweep generator.
package sweep_pkg;

    typedef enum logic [1:0] {
        ModeTri     = 2'd0,
        ModeSawUp   = 2'd1,
        ModeSawDown = 2'd2,
        ModeHold    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2,
        StHold = 2'd3
    } state_e;

    function automatic real code_to_volt(input logic [31:0] code, input real vfs,
                                         input int unsigned w);
        real full;
        full = real'((64'd1 << w) - 64'd1);
        return real'(code) * vfs / full;
    endfunction

endpackage

// File: rtl/sweep_tick.sv
// Step-rate divider: one-cycle strobe every div+1 enabled clocks.
module sweep_tick #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [TW-1:0] div,
    output logic          strobe
);

    logic [TW-1:0] cnt_q, cnt_d;

    assign strobe = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = strobe ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ramp_sweep_gen.sv
// Multi-channel triangle / sawtooth / ramp-hold level sweeper with complementary channel option.
module ramp_sweep_gen
    import sweep_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned W   = 8,
    parameter int unsigned TW  = 8,
    parameter int unsigned CW  = 8,
    parameter real         VFS = 1.5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [W-1:0]          lo,
    input  logic [W-1:0]          hi,
    input  logic [W-1:0]          step,
    input  logic [TW-1:0]         tick_div,
    input  logic [CW-1:0]         n_cycles,
    input  logic [NCH-1:0]        ch_inv,
    output logic [NCH-1:0][W-1:0] code_o,
    output real                   v_o [NCH],
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rising
);

    state_e         state_q, state_d;
    mode_e          mode_q, mode_d;
    logic [W-1:0]   lo_q, lo_d, hi_q, hi_d, step_q, step_d, cur_q, cur_d;
    logic [TW-1:0]  div_q, div_d;
    logic [CW-1:0]  n_q, n_d, cyc_q, cyc_d, cyc_inc;
    logic [NCH-1:0] inv_q, inv_d;
    logic           done_q, done_d, err_q, err_d;
    logic           tick, accept, last_cycle;
    logic [W:0]     up_sum, dn_floor;
    logic [W-1:0]   up_next, dn_next;

    // Saturating neighbours of cur, evaluated one bit wider so nothing wraps.
    assign up_sum     = {1'b0, cur_q} + {1'b0, step_q};
    assign up_next    = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[W-1:0];
    assign dn_floor   = {1'b0, lo_q} + {1'b0, step_q};
    assign dn_next    = ({1'b0, cur_q} < dn_floor) ? lo_q : cur_q - step_q;
    assign cyc_inc    = cyc_q + CW'(1);
    assign last_cycle = (n_q != '0) && (cyc_inc == n_q);

    sweep_tick #(
        .TW(TW)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .clr   (accept | abort),
        .div   (div_q),
        .strobe(tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        div_d   = div_q;
        n_d     = n_q;
        inv_d   = inv_q;
        cur_d   = cur_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;

        if (abort) begin
            state_d = StIdle;
            cur_d   = lo_q;
            cyc_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (lo < hi) begin
                            accept  = 1'b1;
                            mode_d  = mode_e'(mode);
                            lo_d    = lo;
                            hi_d    = hi;
                            step_d  = (step == '0) ? W'(1) : step;
                            div_d   = tick_div;
                            n_d     = n_cycles;
                            inv_d   = ch_inv;
                            cyc_d   = '0;
                            state_d = (mode_e'(mode) == ModeSawDown) ? StDown : StUp;
                            cur_d   = (mode_e'(mode) == ModeSawDown) ? hi : lo;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StUp: begin
                    if (tick) begin
                        if (cur_q == hi_q) begin
                            case (mode_q)
                                ModeSawUp: begin
                                    if (last_cycle) begin
                                        state_d = StIdle;
                                        done_d  = 1'b1;
                                    end else begin
                                        cyc_d = cyc_inc;
                                        cur_d = lo_q;
                                    end
                                end
                                ModeHold: begin
                                    state_d = StHold;
                                    cyc_d   = cyc_inc;
                                end
                                default: begin
                                    state_d = StDown;
                                    cur_d   = dn_next;
                                end
                            endcase
                        end else begin
                            cur_d = up_next;
                        end
                    end
                end
                StDown: begin
                    if (tick) begin
                        if (cur_q == lo_q) begin
                            if (last_cycle) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end else begin
                                cyc_d = cyc_inc;
                                if (mode_q == ModeTri) begin
                                    state_d = StUp;
                                    cur_d   = up_next;
                                end else begin
                                    cur_d = hi_q;
                                end
                            end
                        end else begin
                            cur_d = dn_next;
                        end
                    end
                end
                StHold: begin
                    // Parked at hi until abort; n_cycles deliberately ignored.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= ModeTri;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            div_q   <= '0;
            n_q     <= '0;
            inv_q   <= '0;
            cur_q   <= '0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            div_q   <= div_d;
            n_q     <= n_d;
            inv_q   <= inv_d;
            cur_q   <= cur_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign rising = (state_q == StUp);
    assign done   = done_q;
    assign err    = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [W:0] mirror;
        assign mirror    = {1'b0, lo_q} + {1'b0, hi_q} - {1'b0, cur_q};
        assign code_o[g] = inv_q[g] ? mirror[W-1:0] : cur_q;
        assign v_o[g]    = code_to_volt(32'(code_o[g]), VFS, W);
    end

endmodule

// File: tb/tb_ramp_sweep_gen.sv
// Directed self-checking bench for ramp_sweep_gen with default parameters.
module tb_ramp_sweep_gen;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [1:0]      mode;
    logic [7:0]      lo;
    logic [7:0]      hi;
    logic [7:0]      step;
    logic [7:0]      tick_div;
    logic [7:0]      n_cycles;
    logic [1:0]      ch_inv;
    logic [1:0][7:0] code_o;
    real             v_o [2];
    logic            busy;
    logic            done;
    logic            err;
    logic            rising;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] TriSeq  [8]  = '{8'd3, 8'd6, 8'd9, 8'd10, 8'd7, 8'd4, 8'd1, 8'd0};
    localparam logic [7:0] SawSeq  [8]  = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd2, 8'd4, 8'd6, 8'd8};
    localparam logic [7:0] InvSeq  [10] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd15, 8'd11, 8'd7, 8'd3,
                                            8'd0, 8'd4};
    localparam logic [7:0] HoldSeq [5]  = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd200};

    ramp_sweep_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .step    (step),
        .tick_div(tick_div),
        .n_cycles(n_cycles),
        .ch_inv  (ch_inv),
        .code_o  (code_o),
        .v_o     (v_o),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rising  (rising)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input real obs, input real exp);
        checks++;
        assert (obs > exp - 1.0e-6 && obs < exp + 1.0e-6) else begin
            errors++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [1:0] m, input logic [7:0] l, input logic [7:0] h,
                               input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                               input logic [1:0] inv);
        mode = m; lo = l; hi = h; step = s; tick_div = d; n_cycles = n; ch_inv = inv;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        lo = '0; hi = '0; step = '0; tick_div = '0; n_cycles = '0; ch_inv = '0;
        repeat (2) cyc();
        check8("rst_code0", code_o[0], 8'd0);
        check8("rst_code1", code_o[1], 8'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_rising", rising, 1'b0);
        checkv("rst_v0", v_o[0], 0.0);
        rst = 1'b0;
        cyc();

        // Triangle, one cycle, a step every clock.
        start_sweep(2'd0, 8'd0, 8'd10, 8'd3, 8'd0, 8'd1, 2'b00);
        check8("tri_start", code_o[0], 8'd0);
        check1("tri_busy", busy, 1'b1);
        check1("tri_rising0", rising, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check8("tri_code", code_o[0], TriSeq[i]);
            check1("tri_rising", rising, (i < 4) ? 1'b1 : 1'b0);
            check1("tri_nodone", done, 1'b0);
        end
        cyc();
        check1("tri_done", done, 1'b1);
        check1("tri_busy_drop", busy, 1'b0);
        check8("tri_hold", code_o[0], 8'd0);
        cyc();
        check1("tri_done_pulse", done, 1'b0);

        // Saw-up, two cycles, four clocks per level.
        start_sweep(2'd1, 8'd2, 8'd8, 8'd2, 8'd3, 8'd2, 2'b00);
        for (int k = 0; k < 32; k++) begin
            if (k != 0) cyc();
            check8("saw_code", code_o[0], SawSeq[k/4]);
            check1("saw_busy", busy, 1'b1);
        end
        cyc();
        check1("saw_done", done, 1'b1);
        check1("saw_busy_drop", busy, 1'b0);
        check8("saw_last", code_o[0], 8'd8);
        cyc();
        check1("saw_done_pulse", done, 1'b0);
        check8("saw_idle_hold", code_o[0], 8'd8);

        // Complementary channel, run until abort.
        start_sweep(2'd0, 8'd0, 8'd15, 8'd4, 8'd0, 8'd0, 2'b10);
        for (int k = 0; k < 10; k++) begin
            if (k != 0) cyc();
            check8("inv_ch0", code_o[0], InvSeq[k]);
            check8("inv_ch1", code_o[1], 8'd15 - InvSeq[k]);
            checkv("inv_v0", v_o[0], 1.5 * real'(InvSeq[k]) / 255.0);
            checkv("inv_v1", v_o[1], 1.5 * real'(8'd15 - InvSeq[k]) / 255.0);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check1("inv_abort_busy", busy, 1'b0);
        check1("inv_abort_done", done, 1'b0);
        check8("inv_abort_ch0", code_o[0], 8'd0);
        check8("inv_abort_ch1", code_o[1], 8'd15);

        // Empty range is rejected.
        mode = 2'd0; lo = 8'd9; hi = 8'd9; step = 8'd1; ch_inv = 2'b00;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check1("err_pulse", err, 1'b1);
        check1("err_busy", busy, 1'b0);
        check8("err_code_hold", code_o[0], 8'd0);
        cyc();
        check1("err_clear", err, 1'b0);
        check1("err_busy2", busy, 1'b0);

        // Saw-down with step=0 acting as step=1.
        start_sweep(2'd2, 8'd5, 8'd7, 8'd0, 8'd0, 8'd1, 2'b00);
        check8("sd_start", code_o[0], 8'd7);
        check1("sd_rising", rising, 1'b0);
        cyc();
        check8("sd_code1", code_o[0], 8'd6);
        cyc();
        check8("sd_code2", code_o[0], 8'd5);
        check1("sd_nodone", done, 1'b0);
        cyc();
        check1("sd_done", done, 1'b1);
        check1("sd_busy_drop", busy, 1'b0);
        check8("sd_hold", code_o[0], 8'd5);

        // Start while busy is ignored; abort beats a coincident step and start.
        start_sweep(2'd0, 8'd0, 8'd10, 8'd3, 8'd0, 8'd1, 2'b00);
        start = 1'b1;
        hi = 8'd4;
        cyc();
        start = 1'b0;
        check8("ab_code3", code_o[0], 8'd3);
        cyc();
        check8("ab_old_hi", code_o[0], 8'd6);
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        check1("ab_busy", busy, 1'b0);
        check1("ab_nodone", done, 1'b0);
        check8("ab_code_lo", code_o[0], 8'd0);
        check1("ab_rising", rising, 1'b0);
        cyc();
        check1("ab_busy2", busy, 1'b0);
        check1("ab_nodone2", done, 1'b0);

        // Ramp-hold parks at hi; reset clears everything.
        start_sweep(2'd3, 8'd0, 8'd200, 8'd50, 8'd0, 8'd1, 2'b00);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) cyc();
            check8("rh_code", code_o[0], HoldSeq[k]);
            check1("rh_rising", rising, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            check8("rh_hold", code_o[0], 8'd200);
            check1("rh_busy", busy, 1'b1);
            check1("rh_nodone", done, 1'b0);
            check1("rh_not_rising", rising, 1'b0);
        end
        checkv("rh_v0", v_o[0], 1.5 * 200.0 / 255.0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check8("rr_code0", code_o[0], 8'd0);
        check8("rr_code1", code_o[1], 8'd0);
        check1("rr_busy", busy, 1'b0);
        check1("rr_done", done, 1'b0);
        check1("rr_err", err, 1'b0);
        check1("rr_rising", rising, 1'b0);
        checkv("rr_v0", v_o[0], 0.0);
        checkv("rr_v1", v_o[1], 0.0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
